// File: rtl/alu_sub_seq32_if.sv
// -----------------------------------------------------------------------------
// alu_sub_seq32_if
// Operand-request and result handshake bundle for the sequenced subtractor.
//
//   op_valid / op_ready        operand handshake (requester -> sequencer)
//   op_a, op_b, op_bin         minuend, subtrahend, borrow-in
//   res_valid / res_ready      result handshake (sequencer -> consumer)
//   res_diff                   op_a - op_b - op_bin, mod 2^DATA_W
//   res_borrow/zero/neg/ovf    result flags
//
// Modports: slave  = the sequencer itself
//           master = the requester / result consumer
// -----------------------------------------------------------------------------
interface alu_sub_seq32_if #(
    parameter int DATA_W = 32
);
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_bin;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_diff;
    logic              res_borrow;
    logic              res_zero;
    logic              res_neg;
    logic              res_ovf;

    modport slave (
        input  op_valid, op_a, op_b, op_bin, res_ready,
        output op_ready, res_valid, res_diff, res_borrow, res_zero, res_neg, res_ovf
    );

    modport master (
        output op_valid, op_a, op_b, op_bin, res_ready,
        input  op_ready, res_valid, res_diff, res_borrow, res_zero, res_neg, res_ovf
    );
endinterface

// File: rtl/alu_sub_seq32.sv
// -----------------------------------------------------------------------------
// alu_sub_seq32
// Multi-cycle DATA_W-bit subtractor built around an external SLICE_W-bit
// subtractor slice. The operands are latched, then fed to the slice one
// SLICE_W-bit chunk per cycle (LSB chunk first) with the borrow chained
// between chunks; the per-chunk differences are reassembled into the result.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous abort back to IDLE (beats op_valid/res_ready)
//   bus (slave)         operand and result handshakes, see alu_sub_seq32_if
//   slice_a, slice_b    chunk operands to the external slice
//   slice_ci            borrow into the slice (1 = borrow)
//   slice_diff          chunk difference from the slice (combinational)
//   slice_co            borrow out of the slice (1 = borrow)
//
// Optional feature: define ALU_SUB_SEQ_OVF_EN to generate the signed overflow
// flag; without it res_ovf is tied to 0.
//
// DATA_W must be a multiple of SLICE_W; the chunk count is derived, not set.
// -----------------------------------------------------------------------------
module alu_sub_seq32 #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_sub_seq32_if.slave     bus,
    output logic [SLICE_W-1:0] slice_a,
    output logic [SLICE_W-1:0] slice_b,
    output logic               slice_ci,
    input  logic [SLICE_W-1:0] slice_diff,
    input  logic               slice_co
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e                         state_q, state_d;
    logic                           alive_q;   // low until the first edge after reset
    logic [IDX_W-1:0]               idx_q;
    logic [NSLICE-1:0][SLICE_W-1:0] a_q, b_q, diff_q;
    logic                           bin_q;
    logic                           borrow_q;
    logic                           accept;
    logic                           run_last;
    logic                           done;

    // op_ready is only raised once alive_q is set, so it stays 0 while in reset.
    assign accept   = (state_q == IDLE) && alive_q && bus.op_valid;
    assign run_last = (state_q == RUN) && (idx_q == LAST_IDX);
    assign done     = (state_q == DONE);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = RUN;
            RUN:     if (run_last)      state_d = DONE;
            DONE:    if (bus.res_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        // NOTE: every output gets a default before the case, so no branch can
        // leave one unassigned and infer a latch.
        bus.op_ready  = 1'b0;
        bus.res_valid = 1'b0;
        slice_a       = '0;
        slice_b       = '0;
        slice_ci      = 1'b0;
        unique case (state_q)
            IDLE: bus.op_ready = alive_q;
            RUN: begin
                slice_a  = a_q[idx_q];
                slice_b  = b_q[idx_q];
                slice_ci = (idx_q == '0) ? bin_q : borrow_q;
            end
            DONE:    bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    // Result flags only mean anything once all chunks have been captured.
    assign bus.res_diff   = diff_q;
    assign bus.res_borrow = done && borrow_q;
    assign bus.res_zero   = done && (diff_q == '0);
    assign bus.res_neg    = done && diff_q[NSLICE-1][SLICE_W-1];

    // ----------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand/result registers are cleared too, because
            // res_diff must read 0 while reset is asserted.
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else if (flush) begin
            idx_q <= '0;
        end else if (accept) begin
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            bin_q <= bus.op_bin;
            idx_q <= '0;
        end else if (state_q == RUN) begin
            diff_q[idx_q] <= slice_diff;
            borrow_q      <= slice_co;
            // Wrap explicitly on exit so a non-power-of-two chunk count is safe.
            idx_q         <= run_last ? '0 : idx_q + 1'b1;
        end
    end

    // ------------------------------------------------------- optional overflow
`ifdef ALU_SUB_SEQ_OVF_EN
    logic ovf_q;

    // Captured with the top chunk, whose MSB is the result sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (flush || accept) begin
            ovf_q <= 1'b0;
        end else if (run_last) begin
            ovf_q <= (a_q[NSLICE-1][SLICE_W-1] != b_q[NSLICE-1][SLICE_W-1]) &&
                     (slice_diff[SLICE_W-1] != a_q[NSLICE-1][SLICE_W-1]);
        end
    end

    assign bus.res_ovf = done && ovf_q;
`else
    assign bus.res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sub_seq32.sv
// -----------------------------------------------------------------------------
// tb_alu_sub_seq32
// Self-checking bench for alu_sub_seq32. Emulates the external 8-bit subtractor
// slice, drives directed and random operations, and compares against a
// full-width arithmetic reference. Define ALU_SUB_SEQ_OVF_EN for both this
// bench and the RTL to exercise the overflow flag.
// -----------------------------------------------------------------------------
module tb_alu_sub_seq32;
    localparam int DATA_W  = 32;
    localparam int SLICE_W = 8;
    localparam int NSLICE  = DATA_W / SLICE_W;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic               slice_ci;
    logic [SLICE_W-1:0] slice_diff;
    logic               slice_co;
    logic [SLICE_W:0]   slice_full;

    int n_vec  = 0;
    int n_fail = 0;

    alu_sub_seq32_if #(.DATA_W(DATA_W)) bus ();

    alu_sub_seq32 #(
        .DATA_W (DATA_W),
        .SLICE_W(SLICE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_ci  (slice_ci),
        .slice_diff(slice_diff),
        .slice_co  (slice_co)
    );

    // External subtractor slice: combinational a - b - ci with borrow out.
    assign slice_full = {1'b0, slice_a} - {1'b0, slice_b} - {{SLICE_W{1'b0}}, slice_ci};
    assign slice_diff = slice_full[SLICE_W-1:0];
    assign slice_co   = slice_full[SLICE_W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Borrow entering chunk k = borrow out of the low 8*k bits of a - b - bin.
    function automatic logic exp_ci(input logic [31:0] a, input logic [31:0] b,
                                    input logic bin, input int k);
        logic [63:0] m;
        if (k == 0) return bin;
        m = (64'd1 << (8 * k)) - 64'd1;
        return ({32'd0, a} & m) < (({32'd0, b} & m) + {63'd0, bin});
    endfunction

    task automatic wait_ready();
        int cyc = 0;
        while (!bus.op_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("op_ready_wait", {63'd0, bus.op_ready}, 64'd1);
    endtask

    // Presents one operation and returns at the negedge of the first RUN cycle.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
        wait_ready();
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_bin   = bin;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
        bus.op_bin   = 1'($urandom_range(0, 1));
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                         input int hold);
        logic [32:0] full;
        longint      s;
        logic [31:0] exp_diff;
        logic        exp_borrow;
        logic        exp_ovf;
        int          cyc;

        full       = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        exp_diff   = full[31:0];
        exp_borrow = full[32];
        s          = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
`ifdef ALU_SUB_SEQ_OVF_EN
        exp_ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
        exp_ovf    = 1'b0;
`endif

        start_op(a, b, bin);
        cyc = 1;   // the accept edge counts as the first
        for (int k = 0; k < NSLICE; k++) begin
            check($sformatf("slice_ci[%0d]", k), {63'd0, slice_ci}, {63'd0, exp_ci(a, b, bin, k)});
            check($sformatf("slice_a[%0d]", k), {56'd0, slice_a}, {56'd0, a[8*k +: 8]});
            check($sformatf("slice_b[%0d]", k), {56'd0, slice_b}, {56'd0, b[8*k +: 8]});
            check("res_valid_run", {63'd0, bus.res_valid}, 64'd0);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        while (!bus.res_valid && cyc < 12) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("latency", 64'(cyc), 64'd5);

        bus.op_valid = (hold > 0);
        for (int h = 0; h <= hold; h++) begin
            check("res_valid", {63'd0, bus.res_valid}, 64'd1);
            check("res_diff", {32'd0, bus.res_diff}, {32'd0, exp_diff});
            check("res_borrow", {63'd0, bus.res_borrow}, {63'd0, exp_borrow});
            check("res_zero", {63'd0, bus.res_zero}, {63'd0, (exp_diff == 32'd0)});
            check("res_neg", {63'd0, bus.res_neg}, {63'd0, exp_diff[31]});
            check("res_ovf", {63'd0, bus.res_ovf}, {63'd0, exp_ovf});
            check("op_ready_done", {63'd0, bus.op_ready}, 64'd0);
            if (h < hold) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("res_valid_after", {63'd0, bus.res_valid}, 64'd0);
        check("op_ready_after", {63'd0, bus.op_ready}, 64'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_bin    = 1'b0;
        bus.res_ready = 1'b0;

        // Reset state, before and after an edge with reset held.
        #3;
        check("rst_op_ready", {63'd0, bus.op_ready}, 64'd0);
        check("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
        check("rst_res_diff", {32'd0, bus.res_diff}, 64'd0);
        check("rst_flags", {60'd0, bus.res_borrow, bus.res_zero, bus.res_neg, bus.res_ovf}, 64'd0);
        check("rst_slice", {47'd0, slice_a, slice_b, slice_ci}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_op_ready_edge", {63'd0, bus.op_ready}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("op_ready_first_edge", {63'd0, bus.op_ready}, 64'd1);

        // Directed operations.
        do_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0);
        do_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 10);

        // Reset during RUN at chunk 2: everything clears immediately.
        start_op(32'hA1B2_C3D4, 32'h1122_3344, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("slice_a_idx2", {56'd0, slice_a}, 64'h00000000000000B2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_res_valid", {63'd0, bus.res_valid}, 64'd0);
        check("arst_slice", {47'd0, slice_a, slice_b, slice_ci}, 64'd0);
        check("arst_op_ready", {63'd0, bus.op_ready}, 64'd0);
        check("arst_res_diff", {32'd0, bus.res_diff}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("arst_release_ready", {63'd0, bus.op_ready}, 64'd1);

        // Flush during RUN: back to IDLE, no result pulse.
        start_op(32'h0000_0010, 32'h0000_0001, 1'b0);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_op_ready", {63'd0, bus.op_ready}, 64'd1);
        check("flush_slice", {47'd0, slice_a, slice_b, slice_ci}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            check("flush_no_valid", {63'd0, bus.res_valid}, 64'd0);
            @(posedge clk);
            @(negedge clk);
        end

        // Flush beats op_valid in IDLE.
        bus.op_valid = 1'b1;
        bus.op_a     = 32'h0000_00FF;
        flush        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        flush        = 1'b0;
        check("flush_prio_idle", {63'd0, bus.op_ready}, 64'd1);
        check("flush_prio_slice", {56'd0, slice_a}, 64'd0);

        // Flush in DONE beats res_ready.
        start_op(32'h0000_0009, 32'h0000_0004, 1'b0);
        repeat (NSLICE) @(negedge clk);
        check("flush_done_valid", {63'd0, bus.res_valid}, 64'd1);
        flush         = 1'b1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush         = 1'b0;
        bus.res_ready = 1'b0;
        check("flush_done_idle", {62'd0, bus.res_valid, bus.op_ready}, 64'd1);

        // Random operations.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
